// File: rtl/irq_encoder_8to3_pkg.sv
// Shared widths, FSM state type and helpers for the 8-to-3 interrupt encoder.
package irq_enc_pkg;

    localparam int unsigned N_LINES = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_LINES-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_LINES'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_encoder_8to3_if.sv
// Request/grant bundle between the interrupt sources/consumer and the encoder.
interface irq_encoder_8to3_if;
    import irq_enc_pkg::*;

    logic               en;
    logic [N_LINES-1:0] in;
    logic               ack;
    logic [IDX_W-1:0]   y;
    logic               valid;
    logic [N_LINES-1:0] pending;
    logic               overrun;

    modport master (output en, in, ack, input y, valid, pending, overrun);
    modport slave  (input en, in, ack, output y, valid, pending, overrun);

endinterface

// File: rtl/irq_encoder_8to3_pri_sel_8.sv
// Combinational index selector. Macro IRQ_ENC_ROUND_ROBIN_EN: ascending search from start+1
// with wrap; otherwise descending search from start (start=7 gives highest-index-wins).
module pri_sel_8
    import irq_enc_pkg::*;
(
    input  logic [N_LINES-1:0] vec,
    input  logic [IDX_W-1:0]   start,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W-1:0] cand;

    // First hit in search order wins; index arithmetic wraps mod 8 naturally.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N_LINES; k++) begin
`ifdef IRQ_ENC_ROUND_ROBIN_EN
            cand = start + IDX_W'(k + 1);
`else
            cand = start - IDX_W'(k);
`endif
            if (!found && vec[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_encoder_8to3.sv
// 8-line interrupt encoder with pending register, grant/ack handshake and overrun flag.
// Optional round-robin selection via macro IRQ_ENC_ROUND_ROBIN_EN (default: fixed, bit 7 first).
module irq_encoder_8to3
    import irq_enc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    irq_encoder_8to3_if.slave  bus
);

    state_t             state;
    state_t             state_nxt;
    logic               ack_ok;
    logic [N_LINES-1:0] set_c;
    logic [N_LINES-1:0] clr_c;
    logic [N_LINES-1:0] pend_nxt;
    logic               ovr_nxt;
    logic [N_LINES-1:0] sel_vec;
    logic [IDX_W-1:0]   start_c;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [IDX_W-1:0]   y_nxt;
    logic               valid_nxt;

    assign ack_ok   = (state == GRANT) && bus.ack;
    assign set_c    = bus.en ? bus.in : '0;
    assign clr_c    = ack_ok ? onehot(bus.y) : '0;
    assign pend_nxt = (bus.pending & ~clr_c) | set_c;
    assign ovr_nxt  = |(set_c & bus.pending & ~clr_c);

    // IDLE grants from the registered vector; an ack regrants from the post-update vector.
    assign sel_vec  = (state == GRANT) ? pend_nxt : bus.pending;

`ifdef IRQ_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;

    // Pointer follows the last accepted index; the search uses its updated value.
    assign start_c = ack_ok ? bus.y : ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= IDX_W'(N_LINES - 1);
        end else if (ack_ok) begin
            ptr <= bus.y;
        end
    end
`else
    assign start_c = IDX_W'(N_LINES - 1);
`endif

    pri_sel_8 u_sel (
        .vec   (sel_vec),
        .start (start_c),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state;
        y_nxt     = bus.y;
        valid_nxt = bus.valid;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = GRANT;
                    y_nxt     = sel_idx;
                    valid_nxt = 1'b1;
                end
            end
            GRANT: begin
                if (bus.ack) begin
                    if (sel_found) begin
                        y_nxt = sel_idx;
                    end else begin
                        state_nxt = IDLE;
                        y_nxt     = '0;
                        valid_nxt = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus.y       <= '0;
            bus.valid   <= 1'b0;
            bus.pending <= '0;
            bus.overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            bus.y       <= y_nxt;
            bus.valid   <= valid_nxt;
            bus.pending <= pend_nxt;
            bus.overrun <= ovr_nxt;
        end
    end

endmodule

// File: tb/tb_irq_encoder_8to3.sv
// Scoreboard bench for irq_encoder_8to3; expectations follow IRQ_ENC_ROUND_ROBIN_EN if defined.
module tb_irq_encoder_8to3;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] in;
        logic       ack;
        logic       valid;
        logic [2:0] y;
        logic [7:0] pend;
        logic       ovr;
    } step_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    step_t sb[$];

    irq_encoder_8to3_if bus ();

    irq_encoder_8to3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IRQ_ENC_ROUND_ROBIN_EN
    localparam logic [2:0] BASIC_Y0 = 3'd2;
    localparam logic [2:0] BASIC_Y1 = 3'd5;
    localparam logic [7:0] BASIC_P1 = 8'h20;
    localparam logic [2:0] B2B_YA   = 3'd0;
    localparam logic [2:0] B2B_YB   = 3'd7;
    localparam logic [2:0] MID_Y    = 3'd4;
`else
    localparam logic [2:0] BASIC_Y0 = 3'd5;
    localparam logic [2:0] BASIC_Y1 = 3'd2;
    localparam logic [7:0] BASIC_P1 = 8'h04;
    localparam logic [2:0] B2B_YA   = 3'd7;
    localparam logic [2:0] B2B_YB   = 3'd7;
    localparam logic [2:0] MID_Y    = 3'd7;
`endif

    function automatic step_t mk(logic r, logic e, logic [7:0] i, logic a,
                                 logic v, logic [2:0] yy, logic [7:0] p, logic o);
        step_t s;
        s.rst_n = r; s.en = e; s.in = i; s.ack = a;
        s.valid = v; s.y = yy; s.pend = p; s.ovr = o;
        return s;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; bus.en = 1'b1; bus.in = 8'hFF; bus.ack = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.valid, bus.y, bus.pending, bus.overrun} !== 13'h0) begin
            errors++;
            $display("FAIL reset: got valid=%b y=%0d pending=%h overrun=%b, expected all zero",
                     bus.valid, bus.y, bus.pending, bus.overrun);
        end
        rst_n = 1'b1; bus.en = 1'b0; bus.in = 8'h00; bus.ack = 1'b0;
    endtask

    task automatic test_idle;
        step_t s;
        int n = 0;
        for (int i = 0; i < 10; i++)
            sb.push_back(mk(1, 1, 8'h00, 1'(i % 2), 0, 3'd0, 8'h00, 0));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            rst_n = s.rst_n; bus.en = s.en; bus.in = s.in; bus.ack = s.ack;
            @(posedge clk); #1;
            checks++;
            if ({bus.valid, bus.y, bus.pending, bus.overrun} !== {s.valid, s.y, s.pend, s.ovr}) begin
                errors++;
                $display("FAIL idle[%0d]: got v=%b y=%0d p=%h o=%b, expected v=%b y=%0d p=%h o=%b",
                         n, bus.valid, bus.y, bus.pending, bus.overrun, s.valid, s.y, s.pend, s.ovr);
            end
            n++;
        end
    endtask

    task automatic test_basic;
        step_t s;
        int n = 0;
        sb.push_back(mk(1, 1, 8'h24, 0, 0, 3'd0,     8'h24,    0));
        sb.push_back(mk(1, 1, 8'h00, 0, 1, BASIC_Y0, 8'h24,    0));
        sb.push_back(mk(1, 1, 8'h00, 1, 1, BASIC_Y1, BASIC_P1, 0));
        sb.push_back(mk(1, 1, 8'h00, 1, 0, 3'd0,     8'h00,    0));
        sb.push_back(mk(1, 1, 8'h00, 0, 0, 3'd0,     8'h00,    0));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            rst_n = s.rst_n; bus.en = s.en; bus.in = s.in; bus.ack = s.ack;
            @(posedge clk); #1;
            checks++;
            if ({bus.valid, bus.y, bus.pending, bus.overrun} !== {s.valid, s.y, s.pend, s.ovr}) begin
                errors++;
                $display("FAIL basic[%0d]: got v=%b y=%0d p=%h o=%b, expected v=%b y=%0d p=%h o=%b",
                         n, bus.valid, bus.y, bus.pending, bus.overrun, s.valid, s.y, s.pend, s.ovr);
            end
            n++;
        end
    endtask

    task automatic test_en_off;
        step_t s;
        int n = 0;
        for (int i = 0; i < 3; i++)
            sb.push_back(mk(1, 0, 8'hFF, 1, 0, 3'd0, 8'h00, 0));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            rst_n = s.rst_n; bus.en = s.en; bus.in = s.in; bus.ack = s.ack;
            @(posedge clk); #1;
            checks++;
            if ({bus.valid, bus.y, bus.pending, bus.overrun} !== {s.valid, s.y, s.pend, s.ovr}) begin
                errors++;
                $display("FAIL en_off[%0d]: got v=%b y=%0d p=%h o=%b, expected v=%b y=%0d p=%h o=%b",
                         n, bus.valid, bus.y, bus.pending, bus.overrun, s.valid, s.y, s.pend, s.ovr);
            end
            n++;
        end
    endtask

    task automatic test_overrun;
        step_t s;
        int n = 0;
        sb.push_back(mk(1, 1, 8'h08, 0, 0, 3'd0, 8'h08, 0));
        sb.push_back(mk(1, 1, 8'h00, 0, 1, 3'd3, 8'h08, 0));
        // Re-request while acking the same bit: set wins, no overrun.
        sb.push_back(mk(1, 1, 8'h08, 1, 1, 3'd3, 8'h08, 0));
        sb.push_back(mk(1, 1, 8'h08, 0, 1, 3'd3, 8'h08, 1));
        sb.push_back(mk(1, 1, 8'h00, 0, 1, 3'd3, 8'h08, 0));
        sb.push_back(mk(1, 1, 8'h00, 1, 0, 3'd0, 8'h00, 0));
        sb.push_back(mk(1, 1, 8'h00, 0, 0, 3'd0, 8'h00, 0));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            rst_n = s.rst_n; bus.en = s.en; bus.in = s.in; bus.ack = s.ack;
            @(posedge clk); #1;
            checks++;
            if ({bus.valid, bus.y, bus.pending, bus.overrun} !== {s.valid, s.y, s.pend, s.ovr}) begin
                errors++;
                $display("FAIL overrun[%0d]: got v=%b y=%0d p=%h o=%b, expected v=%b y=%0d p=%h o=%b",
                         n, bus.valid, bus.y, bus.pending, bus.overrun, s.valid, s.y, s.pend, s.ovr);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back;
        step_t s;
        int n = 0;
        sb.push_back(mk(0, 0, 8'h00, 0, 0, 3'd0,   8'h00, 0));
        sb.push_back(mk(1, 1, 8'h81, 1, 0, 3'd0,   8'h81, 0));
        sb.push_back(mk(1, 1, 8'h81, 1, 1, B2B_YA, 8'h81, 1));
        sb.push_back(mk(1, 1, 8'h81, 1, 1, B2B_YB, 8'h81, 1));
        sb.push_back(mk(1, 1, 8'h81, 1, 1, B2B_YA, 8'h81, 1));
        sb.push_back(mk(1, 1, 8'h81, 1, 1, B2B_YB, 8'h81, 1));
        sb.push_back(mk(1, 1, 8'h00, 1, 1, 3'd0,   8'h01, 0));
        sb.push_back(mk(1, 1, 8'h00, 1, 0, 3'd0,   8'h00, 0));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            rst_n = s.rst_n; bus.en = s.en; bus.in = s.in; bus.ack = s.ack;
            @(posedge clk); #1;
            checks++;
            if ({bus.valid, bus.y, bus.pending, bus.overrun} !== {s.valid, s.y, s.pend, s.ovr}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got v=%b y=%0d p=%h o=%b, expected v=%b y=%0d p=%h o=%b",
                         n, bus.valid, bus.y, bus.pending, bus.overrun, s.valid, s.y, s.pend, s.ovr);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid;
        step_t s;
        int n = 0;
        sb.push_back(mk(1, 1, 8'hF0, 0, 0, 3'd0,  8'hF0, 0));
        sb.push_back(mk(1, 1, 8'h00, 0, 1, MID_Y, 8'hF0, 0));
        sb.push_back(mk(0, 1, 8'h0F, 0, 0, 3'd0,  8'h00, 0));
        sb.push_back(mk(1, 0, 8'h00, 0, 0, 3'd0,  8'h00, 0));
        sb.push_back(mk(1, 0, 8'h00, 1, 0, 3'd0,  8'h00, 0));
        sb.push_back(mk(1, 1, 8'h02, 0, 0, 3'd0,  8'h02, 0));
        sb.push_back(mk(1, 1, 8'h00, 0, 1, 3'd1,  8'h02, 0));
        sb.push_back(mk(1, 1, 8'h00, 1, 0, 3'd0,  8'h00, 0));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            rst_n = s.rst_n; bus.en = s.en; bus.in = s.in; bus.ack = s.ack;
            @(posedge clk); #1;
            checks++;
            if ({bus.valid, bus.y, bus.pending, bus.overrun} !== {s.valid, s.y, s.pend, s.ovr}) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got v=%b y=%0d p=%h o=%b, expected v=%b y=%0d p=%h o=%b",
                         n, bus.valid, bus.y, bus.pending, bus.overrun, s.valid, s.y, s.pend, s.ovr);
            end
            n++;
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.in  = 8'h00;
        bus.ack = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_idle();
        test_basic();
        test_en_off();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_encoder_8to3.md
IRQ_ENCODER_8TO3 -- requirements
Module: irq_encoder_8to3

Interface
REQ-001 No parameters; widths SHALL be fixed by package constants (8 request lines, 3-bit index).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 en  input  1  request-capture enable; when 0, `in` SHALL be ignored.
REQ-005 in  input  8  request lines, multi-hot; bit i requests index i.
REQ-006 ack  input  1  consumer accepts the current `y`; meaningful only while valid=1.
REQ-007 y  output  3  registered binary index of the granted request.
REQ-008 valid  output  1  registered; `y` holds a granted index.
REQ-009 pending  output  8  registered pending-request vector.
REQ-010 overrun  output  1  registered one-cycle pulse; a request hit an already-pending, uncleared bit.

Function
REQ-011 Capture: set = en ? in : 8'h00; clr = onehot(y) when valid && ack, else 0.
REQ-012 pending_next SHALL be (pending & ~clr) | set; set SHALL win over clr on the same bit.
REQ-013 overrun_next SHALL be 1 iff |(set & pending & ~clr).
REQ-014 FSM states SHALL be IDLE (valid=0) and GRANT (valid=1).
REQ-015 IDLE: if pending != 0, the block SHALL register y = select(pending) and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-016 GRANT without ack: y and valid SHALL hold stable, even if higher-priority requests arrive.
REQ-017 GRANT with ack: if (pending & ~clr) != 0, the block SHALL stay in GRANT with y = select(pending & ~clr); otherwise it SHALL go to IDLE with valid=0 on the next cycle.
REQ-018 ack while in IDLE SHALL be ignored and SHALL have no effect.
REQ-019 Latency: `in` sampled at edge N -> pending set at N -> valid=1 after edge N+1 (two cycles from stimulus to valid).
REQ-020 Fixed selection: the highest set index SHALL win (bit 7 highest priority).
REQ-021 Back-to-back acks SHALL drain one index per cycle with no idle gap.
REQ-022 y SHALL be 3'b000 whenever valid=0.

Reset
REQ-023 On rst_n=0 at a clk edge: pending=0, y=0, valid=0, overrun=0, state=IDLE, RR pointer=7.
REQ-024 Reset mid-grant SHALL discard all pending requests; `in` is not captured during the reset cycle.

Configuration
REQ-025 Macro IRQ_ENC_ROUND_ROBIN_EN, when defined: selection SHALL search ascending from (ptr+1) mod 8 with wrap-around, and ptr SHALL update to y on each accepted ack.
REQ-026 Macro IRQ_ENC_ROUND_ROBIN_EN, when not defined: fixed priority per REQ-020, with no pointer register.

Structure
REQ-027 Package irq_enc_pkg SHALL hold N_LINES=8, IDX_W=3, and the state typedef (IDLE, GRANT).
REQ-028 Sub-module pri_sel_8 SHALL be a combinational selector taking an 8-bit vector and a 3-bit start pointer, and returning a 3-bit index and a found flag; it SHALL be instantiated once.

Verification
REQ-029 Reset, then in=8'h00, en=1 for 10 cycles -> valid=0, y=0, pending=0 throughout.
REQ-030 en=1, one-cycle pulse in=8'h24 -> pending=8'h24; valid=1, y=5 two cycles after stimulus; ack -> y=2 next cycle; ack -> valid=0, pending=0.
REQ-031 en=0, in=8'hFF -> pending stays 8'h00 and valid stays 0.
REQ-032 While y=3 is granted and pending=8'h08, pulse in=8'h08 with ack=1 in the same cycle -> pending=8'h08, y=3 re-granted, overrun=0; pulse in=8'h08 with ack=0 -> overrun=1 for exactly one cycle.
REQ-033 With IRQ_ENC_ROUND_ROBIN_EN, in=8'h81 held with ack every cycle -> grants alternate 0,7,0,7; without the macro -> grants stay 7,7,7.
REQ-034 With pending=8'hF0 and valid=1, assert rst_n=0 for one cycle -> valid=0, pending=0, y=0; no grant after reset until new requests arrive.
